mcycle_datapath: RTL and testbench
==================================

MCYCLE_DATAPATH -- requirements
Module: mcycle_datapath

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result bit width.
REQ-002 clk  input  1  rising-edge clock, all state sampled here.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 e  input  1  control enable; 0 = hold/no-op word.
REQ-005 s0  input  1  step select; don't-care when e=0.
REQ-006 s1  input  1  add select; don't-care when e=0 or s0=0.
REQ-007 s2  input  1  subtract select; don't-care when e=0 or s0=0.
REQ-008 din_a  input  WIDTH  operand A source.
REQ-009 din_b  input  WIDTH  operand B source.
REQ-010 result  output  WIDTH  registered arithmetic result.
REQ-011 flag  output  1  carry (add) / borrow (sub) of last executed operation.
REQ-012 res_valid  output  1  one-cycle pulse: result/flag updated.
REQ-013 err  output  1  one-cycle pulse: control-sequence violation.
REQ-014 busy  output  1  high when sequence tracker is not IDLE.

Function
REQ-015 Control words decoded per cycle: IDLE_W = e=0; LOAD_A = e=1,s0=0; LOAD_B = e=1,s0=1,s1=0,s2=0; EXEC_ADD = e=1,s0=1,s1=1,s2=0; EXEC_SUB = e=1,s0=1,s1=0,s2=1; ILLEGAL = e=1,s0=1,s1=1,s2=1.
REQ-016 Don't-care inputs (including X) shall not affect state, registers or outputs.
REQ-017 Sequence tracker states: IDLE, GOT_A, GOT_B; busy = (state != IDLE).
REQ-018 IDLE_W in any state: state, RA, RB, result, flag held; no pulses.
REQ-019 LOAD_A in any state: RA <= din_a, state -> GOT_A (restart allowed, no err).
REQ-020 LOAD_B in GOT_A: RB <= din_b, state -> GOT_B; in IDLE or GOT_B: err, state -> IDLE, RB unchanged.
REQ-021 EXEC_ADD in GOT_B: {flag,result} <= RA + RB (WIDTH+1-bit sum), res_valid pulse, state -> IDLE.
REQ-022 EXEC_SUB in GOT_B: result <= RA - RB modulo 2^WIDTH, flag <= (RA < RB) unsigned, res_valid pulse, state -> IDLE.
REQ-023 EXEC_* in IDLE or GOT_A: err pulse, state -> IDLE, result/flag unchanged, no res_valid.
REQ-024 ILLEGAL in any state: err pulse, state -> IDLE, all data registers unchanged.
REQ-025 Latency: result, flag, res_valid, err are registered; visible in the cycle after the word is sampled.
REQ-026 res_valid and err never asserted in the same cycle; each deasserts after one cycle unless retriggered.
REQ-027 Back-to-back sequences (EXEC followed immediately by LOAD_A) shall run with no idle cycle.

Reset
REQ-028 reset high at a clock edge: state -> IDLE, RA, RB, result = 0, flag = 0, res_valid = 0, err = 0, busy = 0.
REQ-029 reset dominates any control word sampled in the same cycle; that word is discarded.
REQ-030 reset mid-sequence (GOT_A/GOT_B) aborts it; subsequent LOAD_B/EXEC without LOAD_A shall raise err.

Configuration
REQ-031 Macro MCDP_SATURATE_EN defined: EXEC_ADD overflow clamps result to all-ones; EXEC_SUB underflow clamps result to 0; flag still reports carry/borrow.
REQ-032 MCDP_SATURATE_EN undefined: results wrap modulo 2^WIDTH per REQ-021/REQ-022.

Verification (WIDTH=8)
REQ-033 LOAD_A din_a=0x12, LOAD_B din_b=0x34, EXEC_ADD -> result=0x46, flag=0, res_valid one cycle, busy 1,1,0.
REQ-034 A=0xF0, B=0x20, EXEC_ADD -> result=0x10, flag=1 (MCDP_SATURATE_EN: result=0xFF, flag=1).
REQ-035 A=0x05, B=0x09, EXEC_SUB -> result=0xFC, flag=1 (MCDP_SATURATE_EN: result=0x00, flag=1).
REQ-036 LOAD_A then EXEC_ADD (no LOAD_B) -> err one cycle, result unchanged, busy=0; ILLEGAL word in GOT_B -> err, state IDLE.
REQ-037 LOAD_A, LOAD_B, reset one cycle, EXEC_ADD -> all outputs 0 after reset, then err pulse, no res_valid.

Source files
------------

// File: rtl/mcycle_datapath.sv
// Multi-cycle add/subtract datapath: LOAD_A, LOAD_B, then EXEC_ADD or EXEC_SUB,
// driven by a per-cycle control word. Defining MCDP_SATURATE_EN clamps results on overflow/underflow.
//
// state | meaning
// IDLE  | no operand sequence in progress
// GOT_A | operand A captured, waiting for LOAD_B
// GOT_B | both operands captured, waiting for EXEC_*
module mcycle_datapath #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             e,
   input  logic             s0,
   input  logic             s1,
   input  logic             s2,
   input  logic [WIDTH-1:0] din_a,
   input  logic [WIDTH-1:0] din_b,
   output logic [WIDTH-1:0] result,
   output logic             flag,
   output logic             res_valid,
   output logic             err,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, GOT_A = 2'd1, GOT_B = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d, result_q, result_d;
   logic             flag_q, flag_d, res_valid_q, res_valid_d, err_q, err_d;

   logic [WIDTH:0]   sum, diff;

   assign sum  = {1'b0, ra_q} + {1'b0, rb_q};
   assign diff = {1'b0, ra_q} - {1'b0, rb_q};

   // Decode is nested so that don't-care select bits are never examined.
   always_comb begin
      state_d     = state_q;
      ra_d        = ra_q;
      rb_d        = rb_q;
      result_d    = result_q;
      flag_d      = flag_q;
      res_valid_d = 1'b0;
      err_d       = 1'b0;
      if (e) begin
         if (!s0) begin
            ra_d    = din_a;
            state_d = GOT_A;
         end else begin
            case ({s1, s2})
               2'b00: begin
                  if (state_q == GOT_A) begin
                     rb_d    = din_b;
                     state_d = GOT_B;
                  end else begin
                     err_d   = 1'b1;
                     state_d = IDLE;
                  end
               end
               2'b10: begin
                  state_d = IDLE;
                  if (state_q == GOT_B) begin
                     res_valid_d = 1'b1;
                     flag_d      = sum[WIDTH];
`ifdef MCDP_SATURATE_EN
                     result_d    = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
                     result_d    = sum[WIDTH-1:0];
`endif
                  end else begin
                     err_d = 1'b1;
                  end
               end
               2'b01: begin
                  state_d = IDLE;
                  if (state_q == GOT_B) begin
                     res_valid_d = 1'b1;
                     flag_d      = diff[WIDTH];
`ifdef MCDP_SATURATE_EN
                     result_d    = diff[WIDTH] ? {WIDTH{1'b0}} : diff[WIDTH-1:0];
`else
                     result_d    = diff[WIDTH-1:0];
`endif
                  end else begin
                     err_d = 1'b1;
                  end
               end
               default: begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         ra_q        <= '0;
         rb_q        <= '0;
         result_q    <= '0;
         flag_q      <= 1'b0;
         res_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ra_q        <= ra_d;
         rb_q        <= rb_d;
         result_q    <= result_d;
         flag_q      <= flag_d;
         res_valid_q <= res_valid_d;
         err_q       <= err_d;
      end
   end

   assign result    = result_q;
   assign flag      = flag_q;
   assign res_valid = res_valid_q;
   assign err       = err_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mcycle_datapath.sv
// Self-checking bench for mcycle_datapath: directed scenarios with literal
// expectations, then random control words checked against an operand-tracking model.
module tb_mcycle_datapath;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset, e, s0, s1, s2;
   logic [W-1:0] din_a, din_b, result;
   logic         flag, res_valid, err, busy;

   int n_pass = 0;
   int n_total = 0;

   // model: which operands are held, their values, expected outputs
   bit           have_a, have_b;
   int           m_ra, m_rb, m_result;
   bit           m_flag, m_rv, m_err;

   localparam int K_IDLE = 0, K_LA = 1, K_LB = 2, K_ADD = 3, K_SUB = 4, K_ILL = 5, K_RST = 6;

   mcycle_datapath #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .e(e), .s0(s0), .s1(s1), .s2(s2),
      .din_a(din_a), .din_b(din_b), .result(result), .flag(flag),
      .res_valid(res_valid), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_apply(input int k, input int a, input int b);
      int sum, dif;
      m_rv  = 0;
      m_err = 0;
      case (k)
         K_RST: begin
            have_a = 0; have_b = 0; m_ra = 0; m_rb = 0; m_result = 0; m_flag = 0;
         end
         K_LA: begin
            m_ra = a; have_a = 1; have_b = 0;
         end
         K_LB: begin
            if (have_a && !have_b) begin
               m_rb = b; have_b = 1;
            end else begin
               m_err = 1; have_a = 0; have_b = 0;
            end
         end
         K_ADD, K_SUB: begin
            if (have_b) begin
               m_rv = 1;
               if (k == K_ADD) begin
                  sum    = m_ra + m_rb;
                  m_flag = (sum > 255);
`ifdef MCDP_SATURATE_EN
                  m_result = m_flag ? 255 : sum;
`else
                  m_result = sum % 256;
`endif
               end else begin
                  dif    = m_ra - m_rb;
                  m_flag = (dif < 0);
`ifdef MCDP_SATURATE_EN
                  m_result = m_flag ? 0 : dif;
`else
                  m_result = (dif + 256) % 256;
`endif
               end
            end else begin
               m_err = 1;
            end
            have_a = 0; have_b = 0;
         end
         K_ILL: begin
            m_err = 1; have_a = 0; have_b = 0;
         end
         default: ;
      endcase
   endtask

   task automatic compare_all();
      check("result", int'(result), m_result);
      check("flag", int'(flag), int'(m_flag));
      check("res_valid", int'(res_valid), int'(m_rv));
      check("err", int'(err), int'(m_err));
      check("busy", int'(busy), int'(have_a));
      check("rv_err_exclusive", int'(res_valid & err), 0);
   endtask

   // Drives one control word (random don't-cares), clocks it in, updates model, compares.
   task automatic step(input int k, input int a, input int b);
      reset = (k == K_RST);
      e  = 1'($urandom); s0 = 1'($urandom); s1 = 1'($urandom); s2 = 1'($urandom);
      case (k)
         K_IDLE: e = 1'b0;
         K_LA:   begin e = 1; s0 = 0; end
         K_LB:   begin e = 1; s0 = 1; s1 = 0; s2 = 0; end
         K_ADD:  begin e = 1; s0 = 1; s1 = 1; s2 = 0; end
         K_SUB:  begin e = 1; s0 = 1; s1 = 0; s2 = 1; end
         K_ILL:  begin e = 1; s0 = 1; s1 = 1; s2 = 1; end
         default: ;
      endcase
      din_a = 8'(a);
      din_b = 8'(b);
      @(posedge clk);
      #1;
      model_apply(k, a, b);
      compare_all();
   endtask

   initial begin
      int k, r;
      reset = 1; e = 0; s0 = 0; s1 = 0; s2 = 0; din_a = 0; din_b = 0;
      #1;
      step(K_RST, 0, 0);
      check("lit_reset_result", int'(result), 0);
      check("lit_reset_busy", int'(busy), 0);

      // 0x12 + 0x34
      step(K_LA, 8'h12, 8'hAA);
      check("lit_busy_after_la", int'(busy), 1);
      step(K_LB, 8'h55, 8'h34);
      check("lit_busy_after_lb", int'(busy), 1);
      step(K_ADD, 0, 0);
      check("lit_add_result", int'(result), 8'h46);
      check("lit_add_flag", int'(flag), 0);
      check("lit_add_rv", int'(res_valid), 1);
      check("lit_add_busy", int'(busy), 0);
      step(K_IDLE, 0, 0);
      check("lit_rv_drops", int'(res_valid), 0);

      // carry case, back-to-back with a subtract
      step(K_LA, 8'hF0, 0);
      step(K_LB, 0, 8'h20);
      step(K_ADD, 0, 0);
`ifdef MCDP_SATURATE_EN
      check("lit_carry_result", int'(result), 8'hFF);
`else
      check("lit_carry_result", int'(result), 8'h10);
`endif
      check("lit_carry_flag", int'(flag), 1);
      step(K_LA, 8'h05, 0);
      step(K_LB, 0, 8'h09);
      step(K_SUB, 0, 0);
`ifdef MCDP_SATURATE_EN
      check("lit_borrow_result", int'(result), 8'h00);
`else
      check("lit_borrow_result", int'(result), 8'hFC);
`endif
      check("lit_borrow_flag", int'(flag), 1);

      // exec without LOAD_B, then ILLEGAL in GOT_B
      step(K_LA, 8'h11, 0);
      step(K_ADD, 0, 0);
      check("lit_noB_err", int'(err), 1);
      check("lit_noB_rv", int'(res_valid), 0);
      check("lit_noB_busy", int'(busy), 0);
      step(K_IDLE, 0, 0);
      check("lit_err_drops", int'(err), 0);
      step(K_LA, 8'h01, 0);
      step(K_LB, 0, 8'h02);
      step(K_ILL, 0, 0);
      check("lit_ill_err", int'(err), 1);
      check("lit_ill_busy", int'(busy), 0);

      // reset mid-sequence aborts it
      step(K_LA, 8'h33, 0);
      step(K_LB, 0, 8'h44);
      step(K_RST, 0, 0);
      check("lit_rst_result", int'(result), 0);
      check("lit_rst_flag", int'(flag), 0);
      check("lit_rst_busy", int'(busy), 0);
      step(K_ADD, 0, 0);
      check("lit_rst_exec_err", int'(err), 1);
      check("lit_rst_exec_rv", int'(res_valid), 0);

      // random words biased toward well-formed sequences
      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 99));
         if      (r < 3)  k = K_RST;
         else if (r < 15) k = K_IDLE;
         else if (r < 40) k = K_LA;
         else if (r < 65) k = K_LB;
         else if (r < 80) k = K_ADD;
         else if (r < 95) k = K_SUB;
         else             k = K_ILL;
         step(k, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
